booth_mult_32b: RTL and testbench

- Sequential signed 32x32 multiplier implementing MIPS `mult`.
- Sits directly downstream of the ALUSrcB operand mux, beside the ALU.
  - Operand A comes from register A.
  - Operand B comes from the ALUSrcB mux output.
- Radix-2 Booth, one step per clock; the 64-bit product is written to the HI/LO outputs.
- The control FSM stalls on `busy` and proceeds on `done`.

---
 rtl/booth_mult_32b.sv | 137 +++++++++++++
 tb/tb_booth_mult_32b.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_32b.sv
// booth_mult_32b -- sequential signed multiplier for MIPS `mult`.
//
// Radix-2 Booth, one recoding step per clock. Operand A comes from register A,
// operand B from the ALUSrcB mux; the 64-bit product lands in hi/lo.
// The control FSM stalls while `busy` is high and proceeds on `done`.
//
// Ports:
//   clk    in   1      system clock, rising-edge active
//   reset  in   1      asynchronous, active-low reset
//   start  in   1      multiply request, sampled only in IDLE
//   a_in   in   WIDTH  multiplicand, two's complement
//   b_in   in   WIDTH  multiplier, two's complement
//   busy   out  1      high while an operation is running
//   done   out  1      one-cycle pulse when hi/lo have just been updated
//   hi     out  WIDTH  upper half of the last completed product
//   lo     out  WIDTH  lower half of the last completed product

module booth_mult_32b #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEPS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [5:0] LAST = 6'(STEPS - 1);

  state_t           state, state_n;

  // acc and mcand carry one extra sign bit so acc - (-2^31) cannot overflow.
  logic [WIDTH:0]   acc, acc_n;
  logic [WIDTH:0]   mcand, mcand_n;
  logic [WIDTH-1:0] q, q_n;
  logic             q_m1, qm1_n;
  logic [5:0]       cnt, cnt_n;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic             busy_n, done_n;

  // One Booth step: conditional add/subtract, then arithmetic shift right of
  // {acc, q, q_m1}.
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh_acc;
  logic [WIDTH-1:0] sh_q;

  always_comb begin
    unique case ({q[0], q_m1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    sh_acc = {sum[WIDTH], sum[WIDTH:1]};
    sh_q   = {sum[0], q[WIDTH-1:1]};
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    mcand_n = mcand;
    q_n     = q;
    qm1_n   = q_m1;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    busy_n  = busy;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          mcand_n = {a_in[WIDTH-1], a_in};
          q_n     = b_in;
          acc_n   = '0;
          qm1_n   = 1'b0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        acc_n = sh_acc;
        q_n   = sh_q;
        qm1_n = q[0];
        cnt_n = cnt + 6'd1;
        // hi/lo are written only on the final step, from the post-shift
        // values, so they never show a partial product.
        if (cnt == LAST) begin
          hi_n    = sh_acc[WIDTH-1:0];
          lo_n    = sh_q;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      mcand <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      mcand <= mcand_n;
      q     <= q_n;
      q_m1  <= qm1_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_booth_mult_32b.sv
// tb_booth_mult_32b -- self-checking bench for booth_mult_32b.
// Expected products are pushed to a scoreboard queue when a request is
// accepted and popped by a monitor whenever the DUT pulses done.

module tb_booth_mult_32b;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a_in, b_in;
  logic        busy, done;
  logic [31:0] hi, lo;

  booth_mult_32b #(.WIDTH(32), .STEPS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb_;
    sa  = $signed({{32{a[31]}}, a});
    sb_ = $signed({{32{b[31]}}, b});
    return 64'(sa * sb_);
  endfunction

  // Monitor: scoreboard compare on done, done width, busy length.
  int   busy_run = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        if (sb.size() == 0) check("unexpected_done", 64'(done), 64'd0);
        else                check("product", {hi, lo}, sb.pop_front());
      end
      if (prev_done) check("done_width", 64'(done), 64'd0);
      if (busy) busy_run++;
      else if (busy_run != 0) begin
        check("busy_len", 64'(busy_run), 64'd32);
        check("done_after_busy", 64'(done), 64'd1);
        busy_run = 0;
      end
      prev_done = done;
    end
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 100);
    if (!done) check("done_timeout", 64'(done), 64'd1);
  endtask

  // Pulse start for one edge, push the expected product, confirm busy.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    sb.push_back(ref_mul(a, b));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic mult(input logic [31:0] a, input logic [31:0] b);
    int c;
    launch(a, b);
    wait_done(c);
  endtask

  typedef struct { logic [31:0] a; logic [31:0] b; logic [63:0] p; } vec_t;
  vec_t dir[4];

  initial begin
    int c;
    reset = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    mult(32'd3, 32'd5);
    check("3x5", {hi, lo}, 64'h0000_0000_0000_000F);

    // Directed signed and extreme cases, against hand-computed products.
    dir[0] = '{32'hFFFF_FFF9, 32'd6,         64'hFFFF_FFFF_FFFF_FFD6};
    dir[1] = '{32'hFFFF_FFFF, 32'd1,         64'hFFFF_FFFF_FFFF_FFFF};
    dir[2] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    dir[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    foreach (dir[i]) begin
      mult(dir[i].a, dir[i].b);
      repeat (2) @(negedge clk);
      check("directed_hold", {hi, lo}, dir[i].p);
    end

    // Start while busy is ignored.
    launch(32'd2, 32'd3);
    repeat (9) @(negedge clk);
    a_in  = 32'd9;
    b_in  = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(c);
    check("ignored_start", {hi, lo}, 64'd6);
    repeat (3) @(negedge clk);
    check("no_restart_busy", 64'(busy), 64'd0);

    // Operand change after capture has no effect.
    launch(32'd11, 32'd13);
    a_in = 32'hDEAD_BEEF;
    b_in = 32'h1234_5678;
    wait_done(c);
    check("operand_capture", {hi, lo}, 64'd143);

    // Start held high: second op accepted in the done cycle.
    a_in  = 32'd100;
    b_in  = 32'hFFFF_FFFD;
    start = 1'b1;
    sb.push_back(ref_mul(32'd100, 32'hFFFF_FFFD));
    wait_done(c);
    a_in = 32'd7;
    b_in = 32'd8;
    sb.push_back(ref_mul(32'd7, 32'd8));
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done(c);
    check("b2b_spacing", 64'(c + 1), 64'd33);
    check("b2b_result", {hi, lo}, 64'd56);

    // Abort mid-operation.
    a_in  = 32'd5;
    b_in  = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_done", 64'(done), 64'd0);
    end
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end
    mult(32'd4, 32'd4);
    check("after_abort", 64'(lo), 64'd16);

    // Random sweep.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: rb = 32'h7FFF_FFFF;
        2: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      mult(ra, rb);
    end

    repeat (3) @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
